// File: rtl/serial_arith_defs_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor and adder variants).
package serial_arith_defs_pkg;

    // Default operand width shared by the serial adder and serial subtractor.
    localparam int SERIAL_DEFAULT_WIDTH = 8;

    // Controller states; the unused code 2'd3 is treated as IDLE by the controllers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin for a single bit position.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);

    // A borrow is produced when b exceeds a, or when a equals b and a borrow came in.
    always_comb begin
        diff   = a ^ b ^ bin;
        borrow = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per clock, LSB first.
module serial_subtractor
    import serial_arith_defs_pkg::*;
#(
    parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             d_bit,
    output logic             d_valid
);

    // Counter only has to reach WIDTH-1, and WIDTH is at least 2.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             r_done;
    logic             r_dBit;
    logic             r_dValid;
    logic             w_cellDiff;
    logic             w_cellBorrow;
    logic             w_last;

    full_subtractor u_cell (
        .a      (r_a[0]),
        .b      (r_b[0]),
        .bin    (r_borrow),
        .diff   (w_cellDiff),
        .borrow (w_cellBorrow)
    );

    assign w_last  = (r_cnt == LAST_STEP);
    assign busy    = (r_state == ST_RUN);
    assign done    = r_done;
    assign diff    = r_diff;
    assign bout    = r_bout;
    assign d_bit   = r_dBit;
    assign d_valid = r_dValid;

    // State register; reset drops straight back to IDLE, aborting any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start only matters in IDLE, RUN lasts WIDTH steps, DONE lasts one cycle.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then one cell evaluation per RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
            r_dBit   <= 1'b0;
            r_dValid <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_dBit   <= 1'b0;
            r_dValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_res    <= {w_cellDiff, r_res[WIDTH-1:1]};
                    r_borrow <= w_cellBorrow;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    r_dBit   <= w_cellDiff;
                    r_dValid <= 1'b1;
                    if (w_last) begin
                        r_diff <= {w_cellDiff, r_res[WIDTH-1:1]};
                        r_bout <= w_cellBorrow;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 directed/random plus WIDTH=4 exhaustive).
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       d_bit;
    logic       d_valid;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;
    logic       d_bit4;
    logic       d_valid4;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .d_bit   (d_bit),
        .d_valid (d_valid)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .bin     (bin4),
        .busy    (busy4),
        .done    (done4),
        .diff    (diff4),
        .bout    (bout4),
        .d_bit   (d_bit4),
        .d_valid (d_valid4)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate-assertion comparison point.
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference model: plain unsigned arithmetic on the operands.
    function automatic logic [8:0] model(input int unsigned av, input int unsigned bv,
                                         input int unsigned bi, input int w);
        int unsigned mask;
        logic [8:0]  r;
        mask = (32'd1 << w) - 1;
        r = '0;
        r[7:0] = 8'((av - bv - bi) & mask);
        r[8]   = (av < bv + bi);
        return r;
    endfunction

    // One WIDTH=8 operation; optionally pulses start again at RUN cycle injectAt.
    task automatic runOp8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input int injectAt);
        logic [8:0] exp;
        logic [7:0] stream;
        logic [7:0] prevDiff;
        int         vcount;
        int         dcount;
        int         firstDone;
        exp       = model(av, bv, bi, 8);
        stream    = '0;
        vcount    = 0;
        dcount    = 0;
        firstDone = -1;
        prevDiff  = diff;
        start = 1'b1; a = av; b = bv; bin = bi;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int c = 1; c <= 12; c++) begin
            if (c == injectAt) begin
                start = 1'b1; a = 8'h01; b = 8'h02; bin = 1'b0;
            end
            if (c == injectAt + 1) start = 1'b0;
            @(posedge clk); #1;
            if (d_valid) begin
                stream = {d_bit, stream[7:1]};
                vcount++;
            end
            if (done) begin
                dcount++;
                if (firstDone < 0) firstDone = c;
            end
            if (c == 1) check({tag, "_hold"}, 32'(diff), 32'(prevDiff));
        end
        check({tag, "_latency"}, 32'(firstDone), 32'd8);
        check({tag, "_donecnt"}, 32'(dcount), 32'd1);
        check({tag, "_vcount"}, 32'(vcount), 32'd8);
        check({tag, "_stream"}, 32'(stream), 32'(exp[7:0]));
        check({tag, "_diff"}, 32'(diff), 32'(exp[7:0]));
        check({tag, "_bout"}, 32'(bout), 32'(exp[8]));
    endtask

    initial begin
        logic [8:0] exp;
        int         nd;
        int         t[2];
        logic [7:0] ds[2];
        logic       bs[2];
        int         vc;
        int         dc;
        logic [3:0] cd;
        logic       cb;

        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_dbit", 32'(d_bit), 32'd0);
        check("rst_dvalid", 32'(d_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: 100 - 58 = 42
        runOp8("t1", 8'd100, 8'd58, 1'b0, 0);

        // Test 2: borrow cases
        runOp8("t2a", 8'h00, 8'h01, 1'b0, 0);
        runOp8("t2b", 8'h55, 8'h55, 1'b1, 0);

        // Test 3: start during RUN is ignored
        runOp8("t3", 8'hFF, 8'h00, 1'b0, 3);

        // Test 4: start held high, back-to-back operations
        nd = 0;
        start = 1'b1; a = 8'd10; b = 8'd3; bin = 1'b0;
        @(posedge clk); #1;
        a = 8'd3; b = 8'd10;
        for (int c = 1; c <= 30; c++) begin
            if (c == 19) start = 1'b0;
            @(posedge clk); #1;
            if (done && nd < 2) begin
                t[nd] = c; ds[nd] = diff; bs[nd] = bout;
            end
            if (done) nd++;
        end
        check("t4_ndone", 32'(nd), 32'd2);
        check("t4_first", 32'(t[0]), 32'd8);
        check("t4_spacing", 32'(t[1] - t[0]), 32'd10);
        check("t4_diff0", 32'(ds[0]), 32'd7);
        check("t4_bout0", 32'(bs[0]), 32'd0);
        check("t4_diff1", 32'(ds[1]), 32'd249);
        check("t4_bout1", 32'(bs[1]), 32'd1);

        // Test 5: asynchronous reset mid-RUN
        start = 1'b1; a = 8'd200; b = 8'd17; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_dvalid", 32'(d_valid), 32'd0);
        check("t5_diff", 32'(diff), 32'd0);
        check("t5_bout", 32'(bout), 32'd0);
        dc = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        check("t5_nodone", 32'(dc), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        runOp8("t5_after", 8'd20, 8'd5, 1'b0, 0);

        // Randomized operations against the model
        for (int i = 0; i < 20; i++) begin
            runOp8("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        // Test 6: WIDTH=4 exhaustive sweep
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    exp = model(av, bv, bi, 4);
                    start4 = 1'b1; a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(bi);
                    @(posedge clk); #1;
                    start4 = 1'b0;
                    vc = 0; dc = 0; cd = '0; cb = 1'b0;
                    for (int c = 1; c <= 6; c++) begin
                        @(posedge clk); #1;
                        if (d_valid4) vc++;
                        if (done4) begin
                            dc++; cd = diff4; cb = bout4;
                        end
                    end
                    check("w4_done", 32'(dc), 32'd1);
                    check("w4_diff", 32'(cd), 32'(exp[3:0]));
                    check("w4_bout", 32'(cb), 32'(exp[8]));
                    check("w4_vcount", 32'(vc), 32'd4);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
